// File: rtl/cq_pkg.sv
// Shared types and default sizing for the audio circular sample queue.
// Optional feature macro used by audio_cqueue: CQ_OVERRUN_EN.
package cq_pkg;

    localparam int DEF_DEPTH = 1024;
    localparam int DEF_TAPS  = 1021;
    localparam int DEF_W     = 16;
    localparam int PTR_W     = $clog2(DEF_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RD   = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEF_W-1:0] lft;
        logic [DEF_W-1:0] rght;
    } pair_t;

endpackage

// File: rtl/cq_dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The array itself has no reset.
module cq_dpram #(
    parameter int DEPTH = 1024,
    parameter int DW    = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/audio_cqueue.sv
// Dual-channel circular sample queue feeding the FIR stage with TAPS-long bursts.
// Define CQ_OVERRUN_EN to add the sticky overrun output.
module audio_cqueue
    import cq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int TAPS  = DEF_TAPS,
    parameter int W     = DEF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wrt_smpl,
    input  logic [W-1:0] lft_smpl,
    input  logic [W-1:0] rght_smpl,
    output logic         sequencing,
    output logic [W-1:0] lft_out,
    output logic [W-1:0] rght_out
`ifdef CQ_OVERRUN_EN
    ,
    output logic         overrun
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] TAPS_PTR  = AW'(TAPS);
    localparam logic [AW-1:0] LAST_CNT  = AW'(TAPS - 1);
    localparam logic [AW:0]   TAPS_FILL = (AW+1)'(TAPS);

    logic [AW-1:0]  new_ptr;
    logic [AW-1:0]  new_ptr_nxt;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  start_ptr;
    logic [AW-1:0]  cnt;
    logic [AW:0]    fill;
    logic [AW:0]    fill_nxt;
    logic           trigger;
    logic           load;
    logic           pending;
    logic           seq_q;
    state_t         state;
    state_t         state_nxt;
    logic [2*W-1:0] rd_data;

    // Burst start uses the write pointer including any write on this edge.
    always_comb begin
        new_ptr_nxt = wrt_smpl ? new_ptr + 1'b1 : new_ptr;
        fill_nxt    = fill;
        if (wrt_smpl && (fill != TAPS_FILL)) begin
            fill_nxt = fill + 1'b1;
        end
        trigger   = wrt_smpl && (fill_nxt == TAPS_FILL);
        start_ptr = new_ptr_nxt - TAPS_PTR;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (trigger || pending) begin
                    state_nxt = RD;
                    load      = 1'b1;
                end
            end
            RD: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A pending burst always passes through IDLE, giving one low cycle of sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_ptr <= '0;
            fill    <= '0;
            state   <= IDLE;
            pending <= 1'b0;
            seq_q   <= 1'b0;
            rd_ptr  <= '0;
            cnt     <= '0;
        end else begin
            new_ptr <= new_ptr_nxt;
            fill    <= fill_nxt;
            state   <= state_nxt;
            seq_q   <= (state == RD);
            if (load) begin
                rd_ptr <= start_ptr;
                cnt    <= '0;
            end else if (state == RD) begin
                rd_ptr <= rd_ptr + 1'b1;
                cnt    <= cnt + 1'b1;
            end
            if (load) begin
                pending <= 1'b0;
            end else if (wrt_smpl && (state == RD)) begin
                pending <= 1'b1;
            end
        end
    end

`ifdef CQ_OVERRUN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (wrt_smpl && pending) begin
            overrun <= 1'b1;
        end
    end
`endif

    cq_dpram #(
        .DEPTH (DEPTH),
        .DW    (2*W)
    ) u_ram (
        .clk   (clk),
        .we    (wrt_smpl),
        .waddr (new_ptr),
        .wdata ({lft_smpl, rght_smpl}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign sequencing = seq_q;
    assign lft_out    = seq_q ? rd_data[2*W-1:W] : '0;
    assign rght_out   = seq_q ? rd_data[W-1:0]   : '0;

endmodule
